// File: rtl/ad_ip_jesd204_tpl_adc_pnmon_pkg.sv
// ----------------------------------------------------------------------------
// ad_ip_jesd204_tpl_adc_pnmon_pkg
// Shared definitions for the multi-channel PN monitor:
//   - pn_seq_sel encodings (4 bits per channel)
//   - polynomial tap pairs (x^N + x^K + 1) for PN7/9/15/23/31
//   - per-channel lock state enum
//   - widths of the error counter and of the match/mismatch counters
// ----------------------------------------------------------------------------
package ad_ip_jesd204_tpl_adc_pnmon_pkg;

    localparam int CNT_W    = 32;   // per-channel error counter width
    localparam int THR_W    = 8;    // thresholds are 1..255
    localparam int SEL_W    = 4;    // pn_seq_sel bits per channel
    localparam int PN_MAX_N = 31;   // longest supported polynomial order

    // Sequence-select encodings
    localparam logic [SEL_W-1:0] SEL_PN9  = 4'd0;
    localparam logic [SEL_W-1:0] SEL_PN23 = 4'd1;
    localparam logic [SEL_W-1:0] SEL_PN7  = 4'd2;
    localparam logic [SEL_W-1:0] SEL_PN15 = 4'd3;
    localparam logic [SEL_W-1:0] SEL_PN31 = 4'd4;

    // Polynomial taps: bit(t) = bit(t-N) ^ bit(t-K)
    localparam int PN7_N  = 7;   localparam int PN7_K  = 6;
    localparam int PN9_N  = 9;   localparam int PN9_K  = 5;
    localparam int PN15_N = 15;  localparam int PN15_K = 14;
    localparam int PN23_N = 23;  localparam int PN23_K = 18;
    localparam int PN31_N = 31;  localparam int PN31_K = 28;

    typedef enum logic {
        ST_OOS    = 1'b0,
        ST_LOCKED = 1'b1
    } pn_state_e;

    // Encodings above SEL_PN31 select no sequence.
    function automatic logic sel_is_valid(input logic [SEL_W-1:0] sel);
        return (sel <= SEL_PN31);
    endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_adc_pnmon_mc_if.sv
// ----------------------------------------------------------------------------
// ad_ip_jesd204_tpl_adc_pnmon_mc_if
// Bundles the PN monitor data/control inputs and status outputs.
//   valid        beat qualifier
//   data         NUM_CHANNELS slices of DATA_PATH_WIDTH samples each
//   pn_seq_sel   4 bits per channel, sequence select
//   err_cnt_clr  per-channel error counter clear
//   pn_oos       per-channel out-of-sync flag
//   pn_err       per-channel mismatch pulse
//   pn_err_cnt   32 bits per channel, error count
// Modports: master (source of data, consumer of status), slave (monitor).
// ----------------------------------------------------------------------------
interface ad_ip_jesd204_tpl_adc_pnmon_mc_if
    import ad_ip_jesd204_tpl_adc_pnmon_pkg::*;
#(
    parameter int NUM_CHANNELS         = 4,
    parameter int CONVERTER_RESOLUTION = 16,
    parameter int DATA_PATH_WIDTH      = 2
);
    localparam int DW = NUM_CHANNELS * DATA_PATH_WIDTH * CONVERTER_RESOLUTION;

    logic                          valid;
    logic [DW-1:0]                 data;
    logic [SEL_W*NUM_CHANNELS-1:0] pn_seq_sel;
    logic [NUM_CHANNELS-1:0]       err_cnt_clr;
    logic [NUM_CHANNELS-1:0]       pn_oos;
    logic [NUM_CHANNELS-1:0]       pn_err;
    logic [CNT_W*NUM_CHANNELS-1:0] pn_err_cnt;

    modport master (
        output valid, data, pn_seq_sel, err_cnt_clr,
        input  pn_oos, pn_err, pn_err_cnt
    );

    modport slave (
        input  valid, data, pn_seq_sel, err_cnt_clr,
        output pn_oos, pn_err, pn_err_cnt
    );

endinterface

// File: rtl/ad_ip_jesd204_tpl_adc_pnmon_ch.sv
// ----------------------------------------------------------------------------
// ad_ip_jesd204_tpl_adc_pnmon_ch
// One PN monitor channel. Builds a check word from the beat's samples
// (sample 0 in the MSBs, i.e. oldest PN bits first), predicts the word from
// either the received history (OOS, self-seeding) or its own PN state
// (LOCKED), and runs the OOS/LOCKED hysteresis.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   i_valid         beat qualifier; nothing advances while low
//   i_data          DATA_PATH_WIDTH samples, sample 0 in the LSBs
//   i_pn_seq_sel    sequence select (see package encodings)
//   i_err_cnt_clr   synchronous error counter clear
//   o_pn_oos        out-of-sync flag (registered state)
//   o_pn_err        one-cycle mismatch pulse while locked
//   o_pn_err_cnt    error count
// Optional feature: define AD_TPL_PNMON_ERR_CNT_EN to build the saturating
// error counter; otherwise o_pn_err_cnt is tied to zero.
// ----------------------------------------------------------------------------
module ad_ip_jesd204_tpl_adc_pnmon_ch
    import ad_ip_jesd204_tpl_adc_pnmon_pkg::*;
#(
    parameter int CONVERTER_RESOLUTION = 16,
    parameter int DATA_PATH_WIDTH      = 2,
    parameter int TWOS_COMPLEMENT      = 1,
    parameter int SYNC_THRESH          = 16,
    parameter int OOS_THRESH           = 4
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            i_valid,
    input  logic [DATA_PATH_WIDTH*CONVERTER_RESOLUTION-1:0] i_data,
    input  logic [SEL_W-1:0]                                i_pn_seq_sel,
    input  logic                                            i_err_cnt_clr,
    output logic                                            o_pn_oos,
    output logic                                            o_pn_err,
    output logic [CNT_W-1:0]                                o_pn_err_cnt
);
    localparam int W  = DATA_PATH_WIDTH * CONVERTER_RESOLUTION;
    localparam int SR = CONVERTER_RESOLUTION;
    // History must hold at least 31 bits so PN31 can be seeded from it.
    localparam int HL = (W > PN_MAX_N) ? W : PN_MAX_N;

    // Offset-binary input: flip the sample MSB to get two's complement.
    localparam logic [SR-1:0] MSB_FLIP =
        (TWOS_COMPLEMENT == 0) ? {1'b1, {(SR-1){1'b0}}} : {SR{1'b0}};
    localparam logic [THR_W-1:0] SYNC_LAST = THR_W'(SYNC_THRESH - 1);
    localparam logic [THR_W-1:0] OOS_LAST  = THR_W'(OOS_THRESH - 1);

    pn_state_e        r_state, w_state_nxt;
    logic [THR_W-1:0] r_mcnt, r_ecnt, w_mcnt_nxt, w_ecnt_nxt;
    logic             r_pn_err, w_err_nxt;
    logic [SEL_W-1:0] r_sel_prev;
    logic [HL-1:0]    r_hist, r_pn, w_hist_nxt, w_pn_nxt, w_seed;
    logic [W-1:0]     w_chk, w_exp;
    logic             w_force, w_match;

    // Extend a bit history by W bits of x^n + x^k + 1. Bit 0 of the seed is
    // the newest bit; the result has its oldest bit in the MSB.
    function automatic logic [W-1:0] pn_next(input logic [HL-1:0] seed,
                                             input int n, input int k);
        logic [HL+W-1:0] ext;
        ext = {seed, {W{1'b0}}};
        for (int i = W - 1; i >= 0; i--) begin
            ext[i] = ext[i+n] ^ ext[i+k];
        end
        return ext[W-1:0];
    endfunction

    // Sample 0 is first in time, so it lands in the check-word MSBs.
    always_comb begin
        w_chk = '0;
        for (int s = 0; s < DATA_PATH_WIDTH; s++) begin
            w_chk[(DATA_PATH_WIDTH-1-s)*SR +: SR] = i_data[s*SR +: SR] ^ MSB_FLIP;
        end
    end

    // Locked channels free-run on their own state so corrupted input does
    // not propagate into the prediction; OOS channels self-seed.
    assign w_seed = (r_state == ST_LOCKED) ? r_pn : r_hist;

    always_comb begin
        w_exp = '0;
        case (i_pn_seq_sel)
            SEL_PN9:  w_exp = pn_next(w_seed, PN9_N,  PN9_K);
            SEL_PN23: w_exp = pn_next(w_seed, PN23_N, PN23_K);
            SEL_PN7:  w_exp = pn_next(w_seed, PN7_N,  PN7_K);
            SEL_PN15: w_exp = pn_next(w_seed, PN15_N, PN15_K);
            SEL_PN31: w_exp = pn_next(w_seed, PN31_N, PN31_K);
            default:  w_exp = '0;
        endcase
    end

    generate
        if (HL > W) begin : g_hist_wide
            assign w_hist_nxt = {r_hist[HL-W-1:0], w_chk};
            assign w_pn_nxt   = {w_seed[HL-W-1:0], w_exp};
        end else begin : g_hist_eq
            assign w_hist_nxt = w_chk;
            assign w_pn_nxt   = w_exp;
        end
    endgenerate

    // An all-zero word never matches, so idle zero data cannot lock.
    assign w_match = (w_chk == w_exp) && (w_chk != '0);
    assign w_force = !sel_is_valid(i_pn_seq_sel) || (i_pn_seq_sel != r_sel_prev);

    always_comb begin
        w_state_nxt = r_state;
        w_mcnt_nxt  = r_mcnt;
        w_ecnt_nxt  = r_ecnt;
        w_err_nxt   = 1'b0;
        if (w_force) begin
            w_state_nxt = ST_OOS;
            w_mcnt_nxt  = '0;
            w_ecnt_nxt  = '0;
        end else if (i_valid) begin
            case (r_state)
                ST_OOS: begin
                    if (!w_match) begin
                        w_mcnt_nxt = '0;
                    end else if (r_mcnt == SYNC_LAST) begin
                        w_state_nxt = ST_LOCKED;
                        w_mcnt_nxt  = '0;
                    end else begin
                        w_mcnt_nxt = r_mcnt + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (w_match) begin
                        w_ecnt_nxt = '0;
                    end else begin
                        // The beat that drops lock still reports its error.
                        w_err_nxt = 1'b1;
                        if (r_ecnt == OOS_LAST) begin
                            w_state_nxt = ST_OOS;
                            w_ecnt_nxt  = '0;
                        end else begin
                            w_ecnt_nxt = r_ecnt + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_OOS;
                    w_mcnt_nxt  = '0;
                    w_ecnt_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_OOS;
            r_mcnt     <= '0;
            r_ecnt     <= '0;
            r_pn_err   <= 1'b0;
            r_sel_prev <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_mcnt     <= w_mcnt_nxt;
            r_ecnt     <= w_ecnt_nxt;
            r_pn_err   <= w_err_nxt;
            r_sel_prev <= i_pn_seq_sel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist <= '0;
            r_pn   <= '0;
        end else if (i_valid) begin
            r_hist <= w_hist_nxt;
            r_pn   <= w_pn_nxt;
        end
    end

    assign o_pn_oos = (r_state == ST_OOS);
    assign o_pn_err = r_pn_err;

`ifdef AD_TPL_PNMON_ERR_CNT_EN
    // Counts on the same edge that raises pn_err; clear has priority.
    logic [CNT_W-1:0] r_err_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_cnt <= '0;
        end else if (i_err_cnt_clr) begin
            r_err_cnt <= '0;
        end else if (w_err_nxt && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign o_pn_err_cnt = r_err_cnt;
`else
    logic w_unused_clr;
    assign w_unused_clr = i_err_cnt_clr;
    assign o_pn_err_cnt = '0;
`endif

endmodule

// File: rtl/ad_ip_jesd204_tpl_adc_pnmon_mc.sv
// ----------------------------------------------------------------------------
// ad_ip_jesd204_tpl_adc_pnmon_mc
// Multi-channel PN sequence monitor for JESD204 transport-layer ADC data.
// Each channel is an independent ad_ip_jesd204_tpl_adc_pnmon_ch instance.
// Ports:
//   clk    sole clock
//   reset  asynchronous active-high reset
//   bus    ad_ip_jesd204_tpl_adc_pnmon_mc_if.slave
//          (valid, data, pn_seq_sel, err_cnt_clr -> pn_oos, pn_err, pn_err_cnt)
// Optional feature: AD_TPL_PNMON_ERR_CNT_EN enables per-channel saturating
// error counters; without it pn_err_cnt reads zero and err_cnt_clr is ignored.
// ----------------------------------------------------------------------------
module ad_ip_jesd204_tpl_adc_pnmon_mc
    import ad_ip_jesd204_tpl_adc_pnmon_pkg::*;
#(
    parameter int NUM_CHANNELS         = 4,
    parameter int CONVERTER_RESOLUTION = 16,
    parameter int DATA_PATH_WIDTH      = 2,
    parameter int TWOS_COMPLEMENT      = 1,
    parameter int SYNC_THRESH          = 16,
    parameter int OOS_THRESH           = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    ad_ip_jesd204_tpl_adc_pnmon_mc_if.slave bus
);
    localparam int W = DATA_PATH_WIDTH * CONVERTER_RESOLUTION;

    generate
        for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
            ad_ip_jesd204_tpl_adc_pnmon_ch #(
                .CONVERTER_RESOLUTION (CONVERTER_RESOLUTION),
                .DATA_PATH_WIDTH      (DATA_PATH_WIDTH),
                .TWOS_COMPLEMENT      (TWOS_COMPLEMENT),
                .SYNC_THRESH          (SYNC_THRESH),
                .OOS_THRESH           (OOS_THRESH)
            ) i_ch (
                .clk           (clk),
                .reset         (reset),
                .i_valid       (bus.valid),
                .i_data        (bus.data[c*W +: W]),
                .i_pn_seq_sel  (bus.pn_seq_sel[c*SEL_W +: SEL_W]),
                .i_err_cnt_clr (bus.err_cnt_clr[c]),
                .o_pn_oos      (bus.pn_oos[c]),
                .o_pn_err      (bus.pn_err[c]),
                .o_pn_err_cnt  (bus.pn_err_cnt[c*CNT_W +: CNT_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_pnmon_mc.sv
// ----------------------------------------------------------------------------
// tb_ad_ip_jesd204_tpl_adc_pnmon_mc
// Directed bench: ch0 PN9, ch1 PN23, ch2 PN7, ch3 PN15, each fed by its own
// bit-serial reference generator. Expected error counts depend on whether
// AD_TPL_PNMON_ERR_CNT_EN is defined.
// ----------------------------------------------------------------------------
module tb_ad_ip_jesd204_tpl_adc_pnmon_mc;
    localparam int NCH = 4;
    localparam int RES = 16;
    localparam int DPW = 2;
    localparam int W   = RES * DPW;
`ifdef AD_TPL_PNMON_ERR_CNT_EN
    localparam logic CNT_EN = 1'b1;
`else
    localparam logic CNT_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference generators: lb[0] is the most recent bit.
    logic [63:0] g_lb [NCH];
    int          g_n  [NCH] = '{9, 23, 7, 15};
    int          g_k  [NCH] = '{5, 18, 6, 14};

    ad_ip_jesd204_tpl_adc_pnmon_mc_if #(
        .NUM_CHANNELS(NCH), .CONVERTER_RESOLUTION(RES), .DATA_PATH_WIDTH(DPW)
    ) bus ();

    ad_ip_jesd204_tpl_adc_pnmon_mc #(
        .NUM_CHANNELS(NCH), .CONVERTER_RESOLUTION(RES), .DATA_PATH_WIDTH(DPW),
        .TWOS_COMPLEMENT(1), .SYNC_THRESH(16), .OOS_THRESH(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // W new bits, first-generated (oldest) bit in the MSB.
    task automatic next_word(input int c, output logic [W-1:0] w);
        logic b;
        w = '0;
        for (int j = W - 1; j >= 0; j--) begin
            b = g_lb[c][g_n[c]-1] ^ g_lb[c][g_k[c]-1];
            g_lb[c] = {g_lb[c][62:0], b};
            w[j] = b;
        end
    endtask

    // One valid beat; corrupt flips bit 3 of the check word, zero sends 0.
    task automatic drive_beat(input logic [NCH-1:0] corrupt, input logic [NCH-1:0] zero);
        logic [W-1:0]     w;
        logic [NCH*W-1:0] d;
        d = '0;
        for (int c = 0; c < NCH; c++) begin
            next_word(c, w);
            if (zero[c])    w = '0;
            if (corrupt[c]) w = w ^ 32'h0000_0008;
            d[c*W +: RES]       = w[W-1 -: RES];
            d[c*W + RES +: RES] = w[RES-1:0];
        end
        bus.data  = d;
        bus.valid = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle_cycle();
        bus.valid = 1'b0;
        bus.data  = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
    endtask

    task automatic run_clean(input int n);
        for (int i = 0; i < n; i++) drive_beat('0, '0);
    endtask

    task automatic test_reset();
        n_tests++;
        if (bus.pn_oos !== 4'hF) begin
            n_fail++; $display("FAIL reset_oos: got %h expected %h", bus.pn_oos, 4'hF);
        end
        n_tests++;
        if (bus.pn_err !== 4'h0) begin
            n_fail++; $display("FAIL reset_err: got %h expected %h", bus.pn_err, 4'h0);
        end
        n_tests++;
        if (bus.pn_err_cnt !== 128'h0) begin
            n_fail++; $display("FAIL reset_cnt: got %h expected 0", bus.pn_err_cnt);
        end
    endtask

    // History is empty after reset, so the first beat can only seed it;
    // lock follows the 16th matching beat.
    task automatic test_lock();
        drive_beat('0, '0);
        for (int i = 1; i <= 16; i++) begin
            drive_beat('0, '0);
            n_tests++;
            if (bus.pn_oos !== ((i < 16) ? 4'hF : 4'h0)) begin
                n_fail++; $display("FAIL lock_oos beat %0d: got %h expected %h",
                                   i, bus.pn_oos, (i < 16) ? 4'hF : 4'h0);
            end
            n_tests++;
            if (bus.pn_err !== 4'h0) begin
                n_fail++; $display("FAIL lock_err beat %0d: got %h expected 0", i, bus.pn_err);
            end
        end
    endtask

    task automatic test_single_err();
        drive_beat(4'b0010, '0);
        n_tests++;
        if (bus.pn_err !== 4'b0010) begin
            n_fail++; $display("FAIL single_err_pulse: got %h expected %h", bus.pn_err, 4'b0010);
        end
        n_tests++;
        if (bus.pn_oos !== 4'h0) begin
            n_fail++; $display("FAIL single_err_oos: got %h expected 0", bus.pn_oos);
        end
        n_tests++;
        if (bus.pn_err_cnt[63:32] !== (CNT_EN ? 32'd1 : 32'd0)) begin
            n_fail++; $display("FAIL single_err_cnt: got %0d expected %0d",
                               bus.pn_err_cnt[63:32], CNT_EN ? 1 : 0);
        end
        drive_beat('0, '0);
        n_tests++;
        if (bus.pn_err !== 4'h0) begin
            n_fail++; $display("FAIL single_err_after: got %h expected 0", bus.pn_err);
        end
        n_tests++;
        if (bus.pn_err_cnt[63:32] !== (CNT_EN ? 32'd1 : 32'd0)) begin
            n_fail++; $display("FAIL single_err_cnt_hold: got %0d expected %0d",
                               bus.pn_err_cnt[63:32], CNT_EN ? 1 : 0);
        end
    endtask

    task automatic test_oos_entry();
        for (int i = 1; i <= 4; i++) begin
            drive_beat(4'b0001, '0);
            n_tests++;
            if (bus.pn_err !== 4'b0001) begin
                n_fail++; $display("FAIL oos_entry_err beat %0d: got %h expected 1", i, bus.pn_err);
            end
            n_tests++;
            if (bus.pn_oos !== ((i == 4) ? 4'b0001 : 4'b0000)) begin
                n_fail++; $display("FAIL oos_entry_oos beat %0d: got %h expected %h",
                                   i, bus.pn_oos, (i == 4) ? 4'b0001 : 4'b0000);
            end
        end
        n_tests++;
        if (bus.pn_err_cnt[31:0] !== (CNT_EN ? 32'd4 : 32'd0)) begin
            n_fail++; $display("FAIL oos_entry_cnt: got %0d expected %0d",
                               bus.pn_err_cnt[31:0], CNT_EN ? 4 : 0);
        end
        // The corrupted word is still in history: one mismatch, then 16 matches.
        run_clean(17);
        n_tests++;
        if (bus.pn_oos !== 4'h0) begin
            n_fail++; $display("FAIL oos_entry_relock: got %h expected 0", bus.pn_oos);
        end
    endtask

    task automatic test_valid_gap();
        for (int i = 0; i < 100; i++) begin
            idle_cycle();
            n_tests++;
            if ({bus.pn_oos, bus.pn_err} !== 8'h00) begin
                n_fail++; $display("FAIL gap_idle cycle %0d: oos=%h err=%h expected 0/0",
                                   i, bus.pn_oos, bus.pn_err);
            end
        end
        for (int i = 0; i < 5; i++) begin
            drive_beat('0, '0);
            n_tests++;
            if ({bus.pn_oos, bus.pn_err} !== 8'h00) begin
                n_fail++; $display("FAIL gap_resume beat %0d: oos=%h err=%h expected 0/0",
                                   i, bus.pn_oos, bus.pn_err);
            end
        end
    endtask

    task automatic test_invalid_sel();
        bus.pn_seq_sel[3:0] = 4'hF;
        for (int i = 0; i < 40; i++) begin
            drive_beat('0, '0);
            n_tests++;
            if ({bus.pn_oos, bus.pn_err} !== 8'h10) begin
                n_fail++; $display("FAIL bad_sel beat %0d: oos=%h err=%h expected 1/0",
                                   i, bus.pn_oos, bus.pn_err);
            end
        end
        bus.pn_seq_sel[3:0] = 4'h0;
        for (int i = 0; i < 40; i++) begin
            drive_beat('0, 4'b0001);
            n_tests++;
            if ({bus.pn_oos, bus.pn_err} !== 8'h10) begin
                n_fail++; $display("FAIL zero_data beat %0d: oos=%h err=%h expected 1/0",
                                   i, bus.pn_oos, bus.pn_err);
            end
        end
        run_clean(17);
        n_tests++;
        if (bus.pn_oos !== 4'h0) begin
            n_fail++; $display("FAIL sel_relock: got %h expected 0", bus.pn_oos);
        end
    endtask

    task automatic test_clr();
        bus.err_cnt_clr = 4'b0010;
        drive_beat(4'b0010, '0);
        bus.err_cnt_clr = 4'b0000;
        n_tests++;
        if (bus.pn_err !== 4'b0010) begin
            n_fail++; $display("FAIL clr_pulse: got %h expected %h", bus.pn_err, 4'b0010);
        end
        n_tests++;
        if (bus.pn_err_cnt[63:32] !== 32'd0) begin
            n_fail++; $display("FAIL clr_wins: got %0d expected 0", bus.pn_err_cnt[63:32]);
        end
        drive_beat(4'b0010, '0);
        n_tests++;
        if (bus.pn_err_cnt[63:32] !== (CNT_EN ? 32'd1 : 32'd0)) begin
            n_fail++; $display("FAIL clr_recount: got %0d expected %0d",
                               bus.pn_err_cnt[63:32], CNT_EN ? 1 : 0);
        end
        bus.err_cnt_clr = 4'hF;
        drive_beat('0, '0);
        bus.err_cnt_clr = 4'h0;
        n_tests++;
        if (bus.pn_err_cnt !== 128'h0) begin
            n_fail++; $display("FAIL clr_all: got %h expected 0", bus.pn_err_cnt);
        end
        n_tests++;
        if (bus.pn_oos !== 4'h0) begin
            n_fail++; $display("FAIL clr_oos: got %h expected 0", bus.pn_oos);
        end
    endtask

    task automatic test_reset_async();
        drive_beat(4'b0100, '0);
        n_tests++;
        if ({bus.pn_oos, bus.pn_err} !== 8'h04) begin
            n_fail++; $display("FAIL pre_reset: oos=%h err=%h expected 0/4", bus.pn_oos, bus.pn_err);
        end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if ({bus.pn_oos, bus.pn_err} !== 8'hF0) begin
            n_fail++; $display("FAIL async_reset: oos=%h err=%h expected F/0", bus.pn_oos, bus.pn_err);
        end
        n_tests++;
        if (bus.pn_err_cnt !== 128'h0) begin
            n_fail++; $display("FAIL async_reset_cnt: got %h expected 0", bus.pn_err_cnt);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        drive_beat('0, '0);
        run_clean(15);
        n_tests++;
        if (bus.pn_oos !== 4'hF) begin
            n_fail++; $display("FAIL relock_early: got %h expected F", bus.pn_oos);
        end
        drive_beat('0, '0);
        n_tests++;
        if (bus.pn_oos !== 4'h0) begin
            n_fail++; $display("FAIL relock: got %h expected 0", bus.pn_oos);
        end
    endtask

    initial begin
        bus.valid       = 1'b0;
        bus.data        = '0;
        bus.pn_seq_sel  = {4'd3, 4'd2, 4'd1, 4'd0};
        bus.err_cnt_clr = '0;
        for (int c = 0; c < NCH; c++) g_lb[c] = 64'h9E37_79B9_7F4A_7C15 ^ 64'(c * 7919);
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        test_lock();
        test_single_err();
        test_oos_entry();
        test_valid_gap();
        test_invalid_sel();
        test_clr();
        test_reset_async();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
